pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen.sv | 130 +++++++++++++
 tb/tb_pc_gen.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Fetch PC generator: trap/redirect/halt/stall priority with a circular return-address stack.
// State advances on the falling clock edge; all outputs come straight from registers.
module pc_gen #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              INC       = 4,
    parameter int              RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            halt_req,
    input  logic            resume,
    input  logic            push_valid,
    input  logic            pop_valid,
    output logic [XLEN-1:0] pc_out,
    output logic            pc_valid,
    output logic [XLEN-1:0] ras_top,
    output logic            ras_empty,
    output logic            ras_full
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    typedef enum logic {RUN, HALTED} state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt, pc_inc;
    logic [XLEN-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]   wr_ptr, ptr_nxt, top_idx, below_idx, wr_idx;
    logic [CW-1:0]   count, count_nxt;
    logic [XLEN-1:0] top_q, top_nxt;
    logic            empty_q, full_q;
    logic            advance, do_push, do_pop, wr_en;

    // wr_ptr names the next free slot, so the top entry sits one below it.
    assign pc_inc    = pc + XLEN'(INC);
    assign top_idx   = wr_ptr - PW'(1);
    assign below_idx = wr_ptr - PW'(2);
    assign advance   = (state == RUN) && !stall && !trap_valid;
    assign do_push   = advance && push_valid;
    // A redirect overrides the prediction, so the stack is left untouched by a pop then.
    assign do_pop    = advance && !redirect_valid && pop_valid && (count != '0);

    always_comb begin
        state_nxt = state;
        if (trap_valid)
            state_nxt = RUN;
        else if (state == RUN && halt_req)
            state_nxt = HALTED;
        else if (state == HALTED && resume)
            state_nxt = RUN;
    end

    always_comb begin
        pc_nxt = pc_inc;
        if (trap_valid)
            pc_nxt = {trap_vec[XLEN-1:2], 2'b00};
        else if (redirect_valid)
            pc_nxt = {redirect_pc[XLEN-1:2], 2'b00};
        else if (state == HALTED || stall)
            pc_nxt = pc;
        else if (do_pop)
            pc_nxt = ras_mem[top_idx];
    end

    always_comb begin
        ptr_nxt   = wr_ptr;
        count_nxt = count;
        top_nxt   = top_q;
        wr_en     = 1'b0;
        wr_idx    = wr_ptr;
        if (trap_valid) begin
            ptr_nxt   = '0;
            count_nxt = '0;
            top_nxt   = '0;
        end else if (do_push && do_pop) begin
            wr_en   = 1'b1;
            wr_idx  = top_idx;
            top_nxt = pc_inc;
        end else if (do_push) begin
            // When full, the slot at wr_ptr holds the oldest entry and is overwritten.
            wr_en     = 1'b1;
            ptr_nxt   = wr_ptr + PW'(1);
            count_nxt = (count == CW'(RAS_DEPTH)) ? count : count + CW'(1);
            top_nxt   = pc_inc;
        end else if (do_pop) begin
            ptr_nxt   = top_idx;
            count_nxt = count - CW'(1);
            top_nxt   = (count == CW'(1)) ? '0 : ras_mem[below_idx];
        end
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            state   <= RUN;
            pc      <= RESET_VEC;
            wr_ptr  <= '0;
            count   <= '0;
            top_q   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            wr_ptr  <= ptr_nxt;
            count   <= count_nxt;
            top_q   <= top_nxt;
            empty_q <= (count_nxt == '0);
            full_q  <= (count_nxt == CW'(RAS_DEPTH));
        end
    end

    always_ff @(negedge clk) begin
        if (!rst && wr_en)
            ras_mem[wr_idx] <= pc_inc;
    end

    assign pc_out    = pc;
    assign pc_valid  = (state == RUN);
    assign ras_top   = top_q;
    assign ras_empty = empty_q;
    assign ras_full  = full_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: inputs change and outputs are sampled 1ns after each falling edge.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst, stall, redirect_valid, trap_valid, halt_req, resume, push_valid, pop_valid;
    logic [31:0] redirect_pc, trap_vec, pc_out, ras_top;
    logic        pc_valid, ras_empty, ras_full;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    pc_gen dut (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .trap_valid(trap_valid), .trap_vec(trap_vec),
        .halt_req(halt_req), .resume(resume),
        .push_valid(push_valid), .pop_valid(pop_valid),
        .pc_out(pc_out), .pc_valid(pc_valid), .ras_top(ras_top),
        .ras_empty(ras_empty), .ras_full(ras_full)
    );

    task automatic idle();
        rst = 0; stall = 0; redirect_valid = 0; redirect_pc = 0; trap_valid = 0; trap_vec = 0;
        halt_req = 0; resume = 0; push_valid = 0; pop_valid = 0;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle(); rst = 1; tick(); tick(); rst = 0;
        checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", pc_out); end
        checks++; if (pc_valid !== 1'b1) begin errors++; $display("FAIL reset_valid got %b want 1", pc_valid); end
        checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", ras_empty); end
        checks++; if (ras_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", ras_full); end
        checks++; if (ras_top !== 32'h0) begin errors++; $display("FAIL reset_top got %h want 0", ras_top); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'h4; exp_pc[1] = 32'h8; exp_pc[2] = 32'hC;
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (pc_out !== exp_pc[i]) begin errors++; $display("FAIL seq_%0d got %h want %h", i, pc_out, exp_pc[i]); end
        end
    endtask

    task automatic test_stall_redirect();
        idle(); tick();
        checks++; if (pc_out !== 32'h10) begin errors++; $display("FAIL pre_stall got %h want 10", pc_out); end
        stall = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (pc_out !== 32'h10) begin errors++; $display("FAIL stall_hold_%0d got %h want 10", i, pc_out); end
        end
        redirect_valid = 1; redirect_pc = 32'h103; tick();
        checks++; if (pc_out !== 32'h100) begin errors++; $display("FAIL stall_redirect got %h want 100", pc_out); end
    endtask

    task automatic test_ras_overflow();
        logic [31:0] at_pc  [5];
        logic [31:0] pop_pc [4];
        at_pc[0] = 32'h20; at_pc[1] = 32'h40; at_pc[2] = 32'h60; at_pc[3] = 32'h80; at_pc[4] = 32'hA0;
        pop_pc[0] = 32'hA4; pop_pc[1] = 32'h84; pop_pc[2] = 32'h64; pop_pc[3] = 32'h44;
        idle(); redirect_valid = 1; redirect_pc = 32'h20; tick();
        // Each push rides on a redirect to the next call site.
        for (int i = 0; i < 5; i++) begin
            idle(); push_valid = 1; redirect_valid = 1;
            redirect_pc = (i < 4) ? at_pc[i+1] : 32'h300;
            tick();
            checks++; if (ras_top !== at_pc[i] + 32'h4) begin errors++; $display("FAIL push_top_%0d got %h want %h", i, ras_top, at_pc[i] + 32'h4); end
        end
        checks++; if (ras_full !== 1'b1) begin errors++; $display("FAIL ras_full got %b want 1", ras_full); end
        idle(); pop_valid = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (pc_out !== pop_pc[i]) begin errors++; $display("FAIL pop_%0d got %h want %h", i, pc_out, pop_pc[i]); end
        end
        tick();
        checks++; if (pc_out !== 32'h48) begin errors++; $display("FAIL pop_empty_pc got %h want 48", pc_out); end
        checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL pop_empty_flag got %b want 1", ras_empty); end
        checks++; if (ras_top !== 32'h0) begin errors++; $display("FAIL pop_empty_top got %h want 0", ras_top); end
    endtask

    task automatic test_push_pop();
        idle(); redirect_valid = 1; redirect_pc = 32'h120; tick();
        idle(); push_valid = 1; redirect_valid = 1; redirect_pc = 32'h200; tick();
        checks++; if (ras_top !== 32'h124) begin errors++; $display("FAIL pp_setup_top got %h want 124", ras_top); end
        idle(); push_valid = 1; pop_valid = 1; tick();
        checks++; if (pc_out !== 32'h124) begin errors++; $display("FAIL pp_pc got %h want 124", pc_out); end
        checks++; if (ras_top !== 32'h204) begin errors++; $display("FAIL pp_top got %h want 204", ras_top); end
        checks++; if (ras_empty !== 1'b0) begin errors++; $display("FAIL pp_empty got %b want 0", ras_empty); end
        idle(); pop_valid = 1; tick();
        checks++; if (pc_out !== 32'h204) begin errors++; $display("FAIL pp_pop_pc got %h want 204", pc_out); end
        checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL pp_pop_empty got %b want 1", ras_empty); end
    endtask

    task automatic test_halt();
        idle(); redirect_valid = 1; redirect_pc = 32'h30; tick();
        idle(); halt_req = 1; tick();
        checks++; if (pc_out !== 32'h34) begin errors++; $display("FAIL halt_pc got %h want 34", pc_out); end
        checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL halt_valid got %b want 0", pc_valid); end
        idle(); push_valid = 1; pop_valid = 1; tick();
        checks++; if (pc_out !== 32'h34) begin errors++; $display("FAIL halt_hold got %h want 34", pc_out); end
        checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL halt_no_push got %b want 1", ras_empty); end
        idle(); redirect_valid = 1; redirect_pc = 32'h80; tick();
        checks++; if (pc_out !== 32'h80) begin errors++; $display("FAIL halt_redirect got %h want 80", pc_out); end
        checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL halt_still got %b want 0", pc_valid); end
        idle(); resume = 1; tick();
        checks++; if (pc_out !== 32'h80) begin errors++; $display("FAIL resume_pc got %h want 80", pc_out); end
        checks++; if (pc_valid !== 1'b1) begin errors++; $display("FAIL resume_valid got %b want 1", pc_valid); end
        idle(); tick();
        checks++; if (pc_out !== 32'h84) begin errors++; $display("FAIL resume_next got %h want 84", pc_out); end
    endtask

    task automatic test_trap_reset();
        idle(); push_valid = 1; tick(); tick();
        checks++; if (ras_top !== 32'h8C) begin errors++; $display("FAIL trap_setup_top got %h want 8c", ras_top); end
        idle(); stall = 1; halt_req = 1; trap_valid = 1; trap_vec = 32'h1000; tick();
        checks++; if (pc_out !== 32'h1000) begin errors++; $display("FAIL trap_pc got %h want 1000", pc_out); end
        checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL trap_empty got %b want 1", ras_empty); end
        checks++; if (ras_top !== 32'h0) begin errors++; $display("FAIL trap_top got %h want 0", ras_top); end
        checks++; if (pc_valid !== 1'b1) begin errors++; $display("FAIL trap_valid_state got %b want 1", pc_valid); end
        idle(); rst = 1; stall = 1; redirect_valid = 1; redirect_pc = 32'h500; tick();
        checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL trap_rst_pc got %h want 0", pc_out); end
        idle(); halt_req = 1; tick();
        idle(); rst = 1; trap_valid = 1; trap_vec = 32'h2000; tick();
        checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL halt_rst_pc got %h want 0", pc_out); end
        checks++; if (pc_valid !== 1'b1) begin errors++; $display("FAIL halt_rst_valid got %b want 1", pc_valid); end
    endtask

    task automatic test_wrap();
        idle(); redirect_valid = 1; redirect_pc = 32'hFFFF_FFFE; tick();
        checks++; if (pc_out !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_align got %h want fffffffc", pc_out); end
        idle(); tick();
        checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h want 0", pc_out); end
    endtask

    initial begin
        idle(); rst = 1;
        test_reset();
        test_sequential();
        test_stall_redirect();
        test_ras_overflow();
        test_push_pop();
        test_halt();
        test_trap_reset();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
